frontend_bundle_queue: RTL and testbench

FRONTEND_BUNDLE_QUEUE -- requirements
Module: frontend_bundle_queue

---
 rtl/frontend_bundle_queue.sv | 115 +++++++++++
 tb/tb_frontend_bundle_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_bundle_queue.sv
// Frontend bundle queue: small circular FIFO between decode and rename.
// Holds decoded instruction pairs and drives the head bundle from storage only.
// After an exception bundle is accepted, enqueue stays blocked until a flush.
module frontend_bundle_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 160,
    parameter int PC_BITS   = 31
) (
    input  logic                       core_clock_i,
    input  logic                       core_reset_ni,
    input  logic                       core_flush_i,
    input  logic                       dec_valid_i,
    input  logic [PAYLOAD_W-1:0]       dec_payload_i,
    input  logic [PC_BITS-1:0]         dec_pc_i,
    input  logic                       dec_ins1_valid_i,
    input  logic                       dec_excp_i,
    output logic                       dec_busy_o,
    output logic                       valid_o,
    output logic [PAYLOAD_W-1:0]       payload_o,
    output logic [PC_BITS-1:0]         pc_o,
    output logic                       ins1_valid_o,
    output logic                       excp_o,
    input  logic                       rn_busy_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       excp_hold_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Entry storage; contents are only observed through the valid-gated head mux.
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [PC_BITS-1:0]   r_pc      [DEPTH];
    logic                 r_ins1    [DEPTH];
    logic                 r_excp    [DEPTH];

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_excp_hold;

    logic                 w_full;
    logic                 w_valid;
    logic                 w_busy;
    logic                 w_enq;
    logic                 w_deq;

    // Handshake decode; busy depends on registers only so decode never waits on rename.
    always_comb begin
        w_full  = (r_occ == OCC_W'(DEPTH));
        w_valid = (r_occ != '0);
        w_busy  = w_full | r_excp_hold;
        w_enq   = dec_valid_i & ~w_busy & ~core_flush_i;
        w_deq   = w_valid & ~rn_busy_i & ~core_flush_i;
    end

    // Pointers, occupancy and exception hold; flush wins over enqueue/dequeue.
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_excp_hold <= 1'b0;
        end else if (core_flush_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_excp_hold <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
                if (dec_excp_i) begin
                    r_excp_hold <= 1'b1;
                end
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Write the incoming bundle at the tail slot.
    always_ff @(posedge core_clock_i) begin
        if (w_enq) begin
            r_payload[r_tail] <= dec_payload_i;
            r_pc[r_tail]      <= dec_pc_i;
            r_ins1[r_tail]    <= dec_ins1_valid_i;
            r_excp[r_tail]    <= dec_excp_i;
        end
    end

    // Head outputs come from storage, forced to zero when empty (and thus in reset).
    always_comb begin
        valid_o      = w_valid;
        dec_busy_o   = w_busy;
        occupancy_o  = r_occ;
        excp_hold_o  = r_excp_hold;
        payload_o    = '0;
        pc_o         = '0;
        ins1_valid_o = 1'b0;
        excp_o       = 1'b0;
        if (w_valid) begin
            payload_o    = r_payload[r_head];
            pc_o         = r_pc[r_head];
            ins1_valid_o = r_ins1[r_head];
            excp_o       = r_excp[r_head];
        end
    end

endmodule

// File: tb/tb_frontend_bundle_queue.sv
// Randomized and directed bench for frontend_bundle_queue with a queue-based model.
module tb_frontend_bundle_queue;

    localparam int DEPTH     = 4;
    localparam int PAYLOAD_W = 160;
    localparam int PC_BITS   = 31;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   dv;
    logic [PAYLOAD_W-1:0]   dpl;
    logic [PC_BITS-1:0]     dpc;
    logic                   di1;
    logic                   dex;
    logic                   dbusy;
    logic                   vld;
    logic [PAYLOAD_W-1:0]   pl;
    logic [PC_BITS-1:0]     pc;
    logic                   i1;
    logic                   ex;
    logic                   rnb;
    logic [$clog2(DEPTH):0] occ;
    logic                   hold;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [PAYLOAD_W-1:0] pl;
        logic [PC_BITS-1:0]   pc;
        logic                 i1;
        logic                 ex;
    } ent_t;

    ent_t m_q[$];
    bit   m_hold;

    frontend_bundle_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .PC_BITS(PC_BITS)) dut (
        .core_clock_i    (clk),
        .core_reset_ni   (rst_n),
        .core_flush_i    (flush),
        .dec_valid_i     (dv),
        .dec_payload_i   (dpl),
        .dec_pc_i        (dpc),
        .dec_ins1_valid_i(di1),
        .dec_excp_i      (dex),
        .dec_busy_o      (dbusy),
        .valid_o         (vld),
        .payload_o       (pl),
        .pc_o            (pc),
        .ins1_valid_o    (i1),
        .excp_o          (ex),
        .rn_busy_i       (rnb),
        .occupancy_o     (occ),
        .excp_hold_o     (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PAYLOAD_W-1:0] rnd_pl();
        logic [PAYLOAD_W-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Drive one cycle of inputs, take the edge, advance the model, settle.
    task automatic cycle(input bit v, input logic [PC_BITS-1:0] p, input bit x1,
                         input bit xe, input bit rb, input bit fl);
        bit   busy;
        bit   deq;
        ent_t e;
        dv = v; dpc = p; di1 = x1; dex = xe; rnb = rb; flush = fl; dpl = rnd_pl();
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_hold = 0;
        end else begin
            busy = (m_q.size() == DEPTH) || m_hold;
            deq  = (m_q.size() != 0) && !rb;
            if (deq) void'(m_q.pop_front());
            if (v && !busy) begin
                e.pl = dpl; e.pc = p; e.i1 = x1; e.ex = xe;
                m_q.push_back(e);
                if (xe) m_hold = 1;
            end
        end
        #1;
        dv = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; dv = 0; flush = 0; rnb = 0; dpl = '0; dpc = '0; di1 = 0; dex = 0;
        m_q.delete(); m_hold = 0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if ({vld, dbusy, occ, hold, ex, i1} !== '0 || pl !== '0 || pc !== '0) begin
            n_err++;
            $display("FAIL reset_state: vld=%b busy=%b occ=%0d hold=%b pc=%h", vld, dbusy, occ, hold, pc);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [PAYLOAD_W-1:0] exp_pl;
        cycle(1, 31'h100, 1, 0, 0, 0);
        exp_pl = m_q[0].pl;
        n_vec++;
        if (vld !== 1'b1 || pc !== 31'h100 || pl !== exp_pl || i1 !== 1'b1 || occ !== 3'd1) begin
            n_err++;
            $display("FAIL single_enq: vld=%b pc=%h occ=%0d i1=%b (want 1 100 1 1)", vld, pc, occ, i1);
        end
        cycle(0, '0, 0, 0, 0, 0);
        n_vec++;
        if (vld !== 1'b0 || occ !== 3'd0) begin
            n_err++;
            $display("FAIL single_deq: vld=%b occ=%0d (want 0 0)", vld, occ);
        end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < 4; i++) cycle(1, 31'h10 + 31'(i), 0, 0, 1, 0);
        n_vec++;
        if (occ !== 3'd4 || dbusy !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: occ=%0d busy=%b (want 4 1)", occ, dbusy);
        end
        cycle(1, 31'h14, 0, 0, 1, 0);
        n_vec++;
        if (occ !== 3'd4 || pc !== 31'h10) begin
            n_err++;
            $display("FAIL fill_fifth_ignored: occ=%0d pc=%h (want 4 10)", occ, pc);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (vld !== 1'b1 || pc !== 31'h10 + 31'(i)) begin
                n_err++;
                $display("FAIL drain_order[%0d]: vld=%b pc=%h want %h", i, vld, pc, 31'h10 + 31'(i));
            end
            cycle(0, '0, 0, 0, 0, 0);
        end
        n_vec++;
        if (occ !== 3'd0 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: occ=%0d vld=%b", occ, vld);
        end
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) cycle(1, 31'h20 + 31'(i), 0, 0, 1, 0);
        cycle(1, 31'h99, 0, 0, 0, 0);
        n_vec++;
        if (occ !== 3'd3 || dbusy !== 1'b0 || pc !== 31'h21) begin
            n_err++;
            $display("FAIL full_deq: occ=%0d busy=%b pc=%h (want 3 0 21)", occ, dbusy, pc);
        end
        repeat (3) cycle(0, '0, 0, 0, 0, 0);
        n_vec++;
        if (occ !== 3'd0) begin
            n_err++;
            $display("FAIL full_deq_drain: occ=%0d (want 0)", occ);
        end
    endtask

    task automatic test_excp();
        cycle(1, 31'h30, 0, 1, 1, 0);
        n_vec++;
        if (hold !== 1'b1 || dbusy !== 1'b1 || occ !== 3'd1 || ex !== 1'b1) begin
            n_err++;
            $display("FAIL excp_hold_set: hold=%b busy=%b occ=%0d ex=%b", hold, dbusy, occ, ex);
        end
        cycle(1, 31'h31, 0, 0, 1, 0);
        n_vec++;
        if (occ !== 3'd1) begin
            n_err++;
            $display("FAIL excp_blocks_enq: occ=%0d (want 1)", occ);
        end
        cycle(0, '0, 0, 0, 0, 0);
        n_vec++;
        if (occ !== 3'd0 || dbusy !== 1'b1 || hold !== 1'b1) begin
            n_err++;
            $display("FAIL excp_drained_busy: occ=%0d busy=%b hold=%b", occ, dbusy, hold);
        end
        cycle(0, '0, 0, 0, 0, 1);
        n_vec++;
        if (hold !== 1'b0 || dbusy !== 1'b0) begin
            n_err++;
            $display("FAIL excp_flush_clear: hold=%b busy=%b (want 0 0)", hold, dbusy);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, 31'h40 + 31'(i), 0, 0, 1, 0);
        cycle(1, 31'h50, 0, 0, 0, 1);
        n_vec++;
        if (occ !== 3'd0 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL flush_priority: occ=%0d vld=%b (want 0 0)", occ, vld);
        end
        cycle(0, '0, 0, 0, 1, 0);
        n_vec++;
        if (occ !== 3'd0 || vld !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_entry: occ=%0d vld=%b", occ, vld);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 31'h60, 1, 0, 1, 0);
        cycle(1, 31'h61, 1, 0, 1, 0);
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({vld, dbusy, occ, hold, ex, i1} !== '0 || pl !== '0 || pc !== '0) begin
            n_err++;
            $display("FAIL async_reset: vld=%b occ=%0d pc=%h i1=%b", vld, occ, pc, i1);
        end
        m_q.delete(); m_hold = 0;
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        cycle(1, 31'h70, 0, 0, 1, 0);
        n_vec++;
        if (vld !== 1'b1 || pc !== 31'h70 || occ !== 3'd1) begin
            n_err++;
            $display("FAIL post_reset_enq: vld=%b pc=%h occ=%0d", vld, pc, occ);
        end
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            cycle(1, 31'h200 + 31'(i), 0, 0, 0, 0);
            n_vec++;
            if (vld !== 1'b1 || pc !== 31'h200 + 31'(i) || occ !== 3'd1) begin
                n_err++;
                $display("FAIL wrap[%0d]: vld=%b pc=%h occ=%0d want pc %h", i, vld, pc, occ, 31'h200 + 31'(i));
            end
        end
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 31'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1), $urandom_range(0, 19) == 0);
            n_vec++;
            if (vld !== (m_q.size() != 0) || occ !== 3'(m_q.size()) || hold !== m_hold ||
                dbusy !== ((m_q.size() == DEPTH) || m_hold)) begin
                n_err++;
                $display("FAIL rand_ctl[%0d]: vld=%b occ=%0d hold=%b busy=%b want occ %0d hold %b",
                         c, vld, occ, hold, dbusy, m_q.size(), m_hold);
            end else if (m_q.size() != 0 &&
                         (pc !== m_q[0].pc || pl !== m_q[0].pl || i1 !== m_q[0].i1 || ex !== m_q[0].ex)) begin
                n_err++;
                $display("FAIL rand_head[%0d]: pc=%h want %h i1=%b/%b ex=%b/%b",
                         c, pc, m_q[0].pc, i1, m_q[0].i1, ex, m_q[0].ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_full_deq();
        test_excp();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
